shiftreg_seq: RTL and testbench

- Parametrised universal shift register with a command sequencer.
- A single `start` command loads the register or shifts/rotates it by `amount` positions, one bit per clock.
- Reports `busy` while running and pulses `done` when finished.
- Sits between a control FSM and serial I/O logic; it is the next generation of the team's 8-bit load/shift/hold register.

---
 rtl/shiftreg_pkg.sv | 24 ++
 rtl/shiftreg_step.sv | 27 ++
 rtl/shiftreg_seq.sv | 97 +++++++++
 tb/tb_shiftreg_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: op codes and FSM states shared by the shift register sequencer.
package shiftreg_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ASR  = 3'd5,
    OP_NOP0 = 3'd6,
    OP_NOP1 = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [2:0] op);
    return op_e'(op) inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR};
  endfunction

endpackage

// File: rtl/shiftreg_step.sv
// shiftreg_step: one single-bit shift/rotate step; non-shift ops pass q through.
module shiftreg_step
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             shiftIn,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (op_e'(op))
      OP_SHR:  begin next_q = {shiftIn, q[WIDTH-1:1]};  out_bit = q[0];       end
      OP_SHL:  begin next_q = {q[WIDTH-2:0], shiftIn};  out_bit = q[WIDTH-1]; end
      OP_ROR:  begin next_q = {q[0], q[WIDTH-1:1]};     out_bit = q[0];       end
      OP_ROL:  begin next_q = {q[WIDTH-2:0], q[WIDTH-1]}; out_bit = q[WIDTH-1]; end
      OP_ASR:  begin next_q = {q[WIDTH-1], q[WIDTH-1:1]}; out_bit = q[0];     end
      default: begin next_q = q;                        out_bit = 1'b0;       end
    endcase
  end

endmodule

// File: rtl/shiftreg_seq.sv
// shiftreg_seq: universal shift register stepping one bit per clock per command.
// Define SHIFTREG_SEQ_ABORT_EN to add an abort input that ends a running command early.
module shiftreg_seq
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef SHIFTREG_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] a,
  input  logic             shiftIn,
  output logic [WIDTH-1:0] q,
  output logic             serialOut,
  output logic             busy,
  output logic             done
);

  state_e           r_state, w_state_nxt;
  logic [2:0]       r_op, w_step_op;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_amt;
  logic [WIDTH-1:0] r_q, w_q_nxt, w_step_q;
  logic             r_out, w_out_nxt, w_step_bit;
  logic             r_busy, r_done, w_done_nxt;
  logic             w_abort, w_go, w_launch, w_step, w_idle;

`ifdef SHIFTREG_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_idle    = r_state == S_IDLE;
  assign w_amt     = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;
  assign w_go      = w_idle && start && is_shift(op) && amount != '0;
  assign w_launch  = w_go && w_amt > CNT_W'(1);
  assign w_step_op = w_idle ? op : r_op;

  shiftreg_step #(.WIDTH(WIDTH)) u_step (
    .q       (r_q),
    .op      (w_step_op),
    .shiftIn (shiftIn),
    .next_q  (w_step_q),
    .out_bit (w_step_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_idle ? (w_launch ? S_SHIFT : S_IDLE)
                         : ((w_abort || r_cnt == CNT_W'(1)) ? S_IDLE : S_SHIFT);
  end

  // An abort cancels the step at its own edge, so q and serialOut hold.
  always_comb begin
    w_step     = w_idle ? w_go : !w_abort;
    w_q_nxt    = w_step ? w_step_q
               : (w_idle && start && op_e'(op) == OP_LOAD) ? a : r_q;
    w_out_nxt  = w_step ? w_step_bit : r_out;
    w_cnt_nxt  = w_idle ? (w_go ? w_amt - CNT_W'(1) : r_cnt)
                        : (w_abort ? '0 : r_cnt - CNT_W'(1));
    w_done_nxt = w_idle ? (start && !w_launch) : (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= '0;
      r_out  <= 1'b0;
      r_cnt  <= '0;
      r_op   <= 3'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_out  <= w_out_nxt;
      r_cnt  <= w_cnt_nxt;
      r_op   <= w_go ? op : r_op;
      r_busy <= w_state_nxt == S_SHIFT;
      r_done <= w_done_nxt;
    end
  end

  assign q         = r_q;
  assign serialOut = r_out;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_shiftreg_seq.sv
// tb_shiftreg_seq: directed command sequence with hand-computed results for WIDTH=8.
module tb_shiftreg_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] amount;
  logic [7:0] a;
  logic       shiftIn;
  logic [7:0] q;
  logic       serialOut, busy, done;
`ifdef SHIFTREG_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int nb;

  shiftreg_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef SHIFTREG_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .op        (op),
    .amount    (amount),
    .a         (a),
    .shiftIn   (shiftIn),
    .q         (q),
    .serialOut (serialOut),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [3:0] n, input logic [7:0] d);
    start = 1'b1; op = o; amount = n; a = d;
    tick();
    start = 1'b0;
  endtask

  // Counts busy cycles until done is seen; a missing done is itself a failure.
  task automatic wait_done(input string tag, output int n);
    bit seen = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) n++;
      tick();
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_with_done"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b1; op = 3'd0; amount = 4'd0; a = 8'hFF; shiftIn = 1'b0;
    tick(); tick();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sout", 32'(serialOut), 32'd0);
    start = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_rst_q", 32'(q), 32'h00);
    chk("post_rst_done", 32'(done), 32'd0);

    issue(3'd0, 4'd0, 8'hAA);
    chk("load_q", 32'(q), 32'hAA);
    chk("load_done", 32'(done), 32'd1);
    chk("load_busy", 32'(busy), 32'd0);
    tick();
    chk("load_done_drop", 32'(done), 32'd0);

    shiftIn = 1'b1;
    issue(3'd1, 4'd3, 8'h00);
    chk("shr_q1", 32'(q), 32'hD5);
    chk("shr_sout1", 32'(serialOut), 32'd0);
    chk("shr_busy1", 32'(busy), 32'd1);
    tick();
    chk("shr_q2", 32'(q), 32'hEA);
    chk("shr_sout2", 32'(serialOut), 32'd1);
    tick();
    chk("shr_q3", 32'(q), 32'hF5);
    chk("shr_sout3", 32'(serialOut), 32'd0);
    chk("shr_done", 32'(done), 32'd1);
    chk("shr_busy3", 32'(busy), 32'd0);
    tick();
    chk("shr_done_drop", 32'(done), 32'd0);
    shiftIn = 1'b0;

    issue(3'd0, 4'd0, 8'h90);
    tick();
    issue(3'd5, 4'd2, 8'h00);
    chk("asr_busy", 32'(busy), 32'd1);
    wait_done("asr", nb);
    chk("asr_q", 32'(q), 32'hE4);
    chk("asr_nbusy", 32'(nb), 32'd1);

    issue(3'd0, 4'd0, 8'h81);
    tick();
    issue(3'd4, 4'd12, 8'h00);
    wait_done("rol", nb);
    chk("rol_q", 32'(q), 32'h81);
    chk("rol_nbusy", 32'(nb), 32'd7);
    chk("rol_sout", 32'(serialOut), 32'd1);

    issue(3'd2, 4'd0, 8'h00);
    chk("shl0_q", 32'(q), 32'h81);
    chk("shl0_done", 32'(done), 32'd1);
    chk("shl0_busy", 32'(busy), 32'd0);
    tick();

    issue(3'd6, 4'd5, 8'h00);
    chk("nop_q", 32'(q), 32'h81);
    chk("nop_done", 32'(done), 32'd1);
    tick();

    shiftIn = 1'b1;
    issue(3'd2, 4'd1, 8'h00);
    chk("shl1_q", 32'(q), 32'h03);
    chk("shl1_sout", 32'(serialOut), 32'd1);
    chk("shl1_done", 32'(done), 32'd1);
    chk("shl1_busy", 32'(busy), 32'd0);
    tick();
    shiftIn = 1'b0;

    issue(3'd0, 4'd0, 8'h81);
    tick();
    issue(3'd1, 4'd5, 8'h00);
    chk("ign_q1", 32'(q), 32'h40);
    start = 1'b1; op = 3'd0; a = 8'h00;
    tick();
    start = 1'b0;
    chk("ign_q2", 32'(q), 32'h20);
    chk("ign_busy", 32'(busy), 32'd1);
    wait_done("ign", nb);
    chk("ign_q", 32'(q), 32'h04);
    chk("ign_nbusy", 32'(nb), 32'd3);

    issue(3'd0, 4'd0, 8'hFF);
    tick();
    issue(3'd1, 4'd4, 8'h00);
    tick();
    chk("rmid_q_pre", 32'(q), 32'h3F);
    reset_n = 1'b0;
    #1;
    chk("rmid_q", 32'(q), 32'h00);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_done", 32'(done), 32'd0);
    tick();
    reset_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) nb++;
      tick();
    end
    chk("rmid_quiet", 32'(nb), 32'd0);
    chk("rmid_q_after", 32'(q), 32'h00);

`ifdef SHIFTREG_SEQ_ABORT_EN
    issue(3'd0, 4'd0, 8'hAA);
    tick();
    issue(3'd1, 4'd3, 8'h00);
    chk("abt_q1", 32'(q), 32'h55);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_q", 32'(q), 32'h55);
    chk("abt_done", 32'(done), 32'd1);
    chk("abt_busy", 32'(busy), 32'd0);
    tick();
    chk("abt_done_drop", 32'(done), 32'd0);
    abort = 1'b1;
    issue(3'd0, 4'd0, 8'h3C);
    abort = 1'b0;
    chk("abt_idle_q", 32'(q), 32'h3C);
    chk("abt_idle_done", 32'(done), 32'd1);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
